// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the register file and its
// write-port arbiter.
package regfile_pkg;

  localparam int REG_W_DEF     = 32;
  localparam int REG_COUNT_DEF = 32;
  localparam int ZERO_REG      = 0;

  // Index width for a count of items; never narrower than one bit.
  function automatic int idx_w(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or above ptr wins,
// otherwise the lowest set request overall.
module rr_picker
  import regfile_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_valid
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick_src;
  logic         found;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
    masked   = req & hi_mask;
    // Nothing at or above the pointer: wrap around to the full request set.
    pick_src = (|masked) ? masked : req;
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pick_src[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        found     = 1'b1;
      end
    end
    any_valid = |req;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// N_REQ writeback sources, with x0 suppression and a collision counter.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int N_REQ     = 2,
  parameter int CNT_W     = 16,
  localparam int REG_IDX_W = idx_w(REG_COUNT),
  localparam int GNT_W     = idx_w(N_REQ)
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*REG_IDX_W-1:0] req_reg,
  input  logic [N_REQ*REG_W-1:0]     req_data,
  input  logic                       wr_stall,
  output logic                       wr_en,
  output logic [REG_IDX_W-1:0]       wr_reg,
  output logic [REG_W-1:0]           wr_data,
  output logic [GNT_W-1:0]           grant_idx,
  output logic                       x0_drop,
  output logic [CNT_W-1:0]           collision_cnt
);

  // Handshake: requester i transfers on an edge where req_valid[i] &&
  // req_ready[i]. req_ready is one-hot-or-zero, combinational, and forced to
  // zero while stalled or in reset; requesters hold valid/reg/data until then.

  logic [GNT_W-1:0]     rr_ptr;
  logic [N_REQ-1:0]     req_eligible;
  logic [GNT_W-1:0]     win_idx;
  logic                 transfer;
  logic [REG_IDX_W-1:0] win_reg;
  logic [REG_W-1:0]     win_data;
  logic                 win_is_x0;
  int                   n_valid;
  logic                 collide;

  assign req_eligible = req_valid & {N_REQ{aresetn & ~wr_stall}};

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (GNT_W)
  ) u_picker (
    .req       (req_eligible),
    .ptr       (rr_ptr),
    .grant     (req_ready),
    .grant_idx (win_idx),
    .any_valid (transfer)
  );

  assign win_reg   = req_reg[win_idx*REG_IDX_W +: REG_IDX_W];
  assign win_data  = req_data[win_idx*REG_W +: REG_W];
  assign win_is_x0 = (win_reg == REG_IDX_W'(ZERO_REG));

  always_comb begin
    n_valid = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) n_valid = n_valid + 1;
    end
    collide = !wr_stall && (n_valid >= 2);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_en         <= 1'b0;
      wr_reg        <= '0;
      wr_data       <= '0;
      grant_idx     <= '0;
      x0_drop       <= 1'b0;
      collision_cnt <= '0;
      rr_ptr        <= '0;
    end else begin
      wr_en   <= transfer && !win_is_x0;
      x0_drop <= transfer && win_is_x0;
      if (transfer) begin
        // x0 writes still update the index/data so the port shows what was dropped.
        wr_reg    <= win_reg;
        wr_data   <= win_data;
        grant_idx <= win_idx;
        rr_ptr    <= (win_idx == GNT_W'(N_REQ - 1)) ? '0 : win_idx + GNT_W'(1);
      end
      if (collide && (collision_cnt != {CNT_W{1'b1}})) begin
        collision_cnt <= collision_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (wr_en/wr_reg/wr_data) among N_REQ writeback sources, e.g. ALU writeback and load writeback.
- Each source uses a valid/ready handshake. Round-robin arbitration picks one winner per cycle and registers it onto the write port one cycle later.
- Writes to x0 are consumed but suppressed.
- A saturating collision counter supports performance visibility.
- Sits between the execute/memory writeback stages and register_file.

Parameters:
- REG_W, 32, data width of one register.
- REG_COUNT, 32, number of architectural registers; REG_IDX_W = $clog2(REG_COUNT).
- N_REQ, 2, number of writeback requesters (>=2).
- CNT_W, 16, width of the collision counter.

Ports:
- clk  input  1  rising-edge clock.
- aresetn  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
- req_valid  input  N_REQ  requester i has a write pending.
- req_ready  output  N_REQ  one-hot-or-zero grant; a transfer occurs when req_valid[i] && req_ready[i].
- req_reg  input  N_REQ*REG_IDX_W  destination index per requester; slice i is bits [i*REG_IDX_W +: REG_IDX_W].
- req_data  input  N_REQ*REG_W  write data per requester; slice i is bits [i*REG_W +: REG_W].
- wr_stall  input  1  downstream hold; while high no grants are issued.
- wr_en  output  1  register_file write enable (registered).
- wr_reg  output  REG_IDX_W  register_file write index (registered).
- wr_data  output  REG_W  register_file write data (registered).
- grant_idx  output  $clog2(N_REQ)  index of the requester whose write is on the port this cycle (registered).
- x0_drop  output  1  one-cycle pulse: the transfer accepted last cycle targeted x0 and was suppressed.
- collision_cnt  output  CNT_W  saturating count of cycles with >=2 valid requests and wr_stall low.

Behaviour:
- Reset (aresetn low at a rising edge):
  - wr_en=0, wr_reg=0, wr_data=0, grant_idx=0, x0_drop=0, collision_cnt=0.
  - Round-robin pointer rr_ptr=0, so requester 0 has top priority.
  - A transfer accepted in the same cycle as reset is discarded; nothing is written.
- req_ready is combinational from req_valid, rr_ptr, wr_stall and aresetn:
  - The winner is the first i with req_valid[i]=1 in the cyclic order rr_ptr, rr_ptr+1, ..., rr_ptr+N_REQ-1 (mod N_REQ).
  - req_ready[winner]=1; all other bits are 0.
  - All bits are 0 when wr_stall=1, when no requester is valid, or when aresetn=0.
- Latency: a transfer at edge t appears on wr_en/wr_reg/wr_data/grant_idx during cycle t+1. The write lands in register_file at edge t+1.
- On a transfer:
  - wr_reg and wr_data take the winner's slices; grant_idx takes the winner index.
  - If the winner's reg != 0: wr_en=1, x0_drop=0.
  - If the winner's reg == 0: wr_en=0, x0_drop=1. wr_reg and wr_data are still updated.
  - rr_ptr becomes (winner+1) mod N_REQ.
- No transfer (stall or no valid request): wr_en=0 and x0_drop=0. wr_reg, wr_data, grant_idx and rr_ptr hold their values.
- Back-to-back: one transfer per cycle sustained; wr_en may stay high on consecutive cycles.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,...,N_REQ-1,0,... Each requester waits at most N_REQ-1 cycles.
- Same destination from two requesters in one cycle: only one is granted. Write ordering between requesters is not guaranteed by this block; upstream hazard logic owns ordering.
- Requester rule: once valid is asserted, valid, reg and data stay stable until the transfer. The arbiter does not check this rule.
- collision_cnt: increments by 1 on each edge where aresetn=1, wr_stall=0 and popcount(req_valid)>=2. It saturates at 2^CNT_W-1 and never wraps.
- wr_stall asserted mid-stream: an already-registered write still drives the port for its one cycle. No new grant is issued until wr_stall drops.

Decomposition:
- Package regfile_pkg:
  - localparam function for REG_IDX_W from REG_COUNT.
  - ZERO_REG = 0.
  - Default REG_W and REG_COUNT constants shared with register_file.
- Sub-module rr_picker: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any_valid.
  - Implemented by double-width masking (mask requests below rr_ptr, fall back to unmasked).
- Top level holds rr_ptr, the output register stage, x0 suppression and collision_cnt.

Test Plan:
- Reset: hold aresetn=0 for 2 edges while req_valid=2'b11 -> req_ready=0, wr_en=0, collision_cnt=0. After release, first grant goes to requester 0.
- Single write: req0 valid, reg=5, data=32'hDEADBEEF at edge t -> wr_en=1, wr_reg=5, wr_data=DEADBEEF, grant_idx=0 in cycle t+1. A register_file read of r5 afterwards returns DEADBEEF.
- Round-robin: both requesters valid for 4 cycles, req0 reg=1, req1 reg=2 -> grant_idx sequence 0,1,0,1. collision_cnt=4 afterwards.
- x0 suppression: req1 writes reg=0, data=32'h12345678 -> wr_en=0, x0_drop=1 for one cycle, req_ready[1] pulsed once. A register_file read of r0 stays 0.
- Stall: both requesters valid, wr_stall=1 for 3 cycles -> req_ready=0, wr_en=0, collision_cnt unchanged, rr_ptr unchanged. On release, the grant goes to the requester rr_ptr pointed at.
- Saturation and reset mid-op: CNT_W=4 with 20 colliding cycles -> collision_cnt=15. Assert reset on a grant edge -> no wr_en in the next cycle and collision_cnt=0.
